// File: rtl/bus_arb_decoder.sv
// Two-master bus arbiter with one-hot slave decode and registered read select.
// Optional fairness hold counter enabled by defining BUS_FAIR_ARB_EN.
module bus_arb_decoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_wr,
    input  logic        m1_wr,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m0_dout,
    input  logic [31:0] m1_dout,
    output logic        m0_grant,
    output logic        m1_grant,
    output logic [15:0] s_addr,
    output logic        s_wr,
    output logic [31:0] s_din,
    output logic [7:0]  s_sel,
    output logic [2:0]  rsel
);

    typedef enum logic {
        M0_GNT = 1'b0,
        M1_GNT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  rsel_q, rsel_d;
    logic        g_req;
    logic        g_wr;
    logic [15:0] g_addr;
    logic [31:0] g_dout;
    logic        both_req;

    assign both_req = m0_req & m1_req;

`ifdef BUS_FAIR_ARB_EN
    logic [1:0] hold_q, hold_d;

    // Fairness: count consecutive contended cycles while M0 owns the bus.
    always_comb begin
        hold_d = 2'd0;
        if (state_q == M0_GNT && both_req && state_d == M0_GNT)
            hold_d = hold_q + 2'd1;
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hold_q <= 2'd0;
        else          hold_q <= hold_d;
    end
`endif

    // Next-state logic: owner keeps the bus until it lets go.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            M0_GNT: begin
                if (!m0_req && m1_req)
                    state_d = M1_GNT;
`ifdef BUS_FAIR_ARB_EN
                else if (both_req && hold_q == 2'd3)
                    state_d = M1_GNT;
`endif
            end
            M1_GNT: begin
                if (!m1_req)
                    state_d = M0_GNT;
            end
            default: state_d = M0_GNT;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= M0_GNT;
        else          state_q <= state_d;
    end

    // Route the granted master onto the slave side.
    always_comb begin
        if (state_q == M1_GNT) begin
            g_req  = m1_req;
            g_wr   = m1_wr;
            g_addr = m1_addr;
            g_dout = m1_dout;
        end else begin
            g_req  = m0_req;
            g_wr   = m0_wr;
            g_addr = m0_addr;
            g_dout = m0_dout;
        end
    end

    // Reads latch the slave index for the downstream read-data mux.
    always_comb begin
        rsel_d = rsel_q;
        if (g_req && !g_wr)
            rsel_d = g_addr[15:13];
    end

    // Read select register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rsel_q <= 3'd0;
        else          rsel_q <= rsel_d;
    end

    assign m0_grant = (state_q == M0_GNT);
    assign m1_grant = (state_q == M1_GNT);
    assign s_addr   = g_addr;
    assign s_din    = g_dout;
    assign s_wr     = g_wr & g_req;
    assign s_sel    = g_req ? (8'd1 << g_addr[15:13]) : 8'h00;
    assign rsel     = rsel_q;

endmodule

// File: tb/tb_bus_arb_decoder.sv
// Directed bench for bus_arb_decoder with an expected-value scoreboard.
// Expectations for contention follow BUS_FAIR_ARB_EN when it is defined.
module tb_bus_arb_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m1_req, m0_wr, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_dout, m1_dout;
    logic        m0_grant, m1_grant;
    logic [15:0] s_addr;
    logic        s_wr;
    logic [31:0] s_din;
    logic [7:0]  s_sel;
    logic [2:0]  rsel;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic        m0g;
        logic        m1g;
        logic [7:0]  sel;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] din;
        logic [2:0]  rsel;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bus_arb_decoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m0_wr    (m0_wr),
        .m1_wr    (m1_wr),
        .m0_addr  (m0_addr),
        .m1_addr  (m1_addr),
        .m0_dout  (m0_dout),
        .m1_dout  (m1_dout),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant),
        .s_addr   (s_addr),
        .s_wr     (s_wr),
        .s_din    (s_din),
        .s_sel    (s_sel),
        .rsel     (rsel)
    );

    task automatic push(input string tag, input logic m0g,
                        input logic [7:0] sel, input logic wr,
                        input logic [15:0] addr, input logic [31:0] din,
                        input logic [2:0] rs);
        exp_t e;
        e.tag  = tag;
        e.m0g  = m0g;
        e.m1g  = ~m0g;
        e.sel  = sel;
        e.wr   = wr;
        e.addr = addr;
        e.din  = din;
        e.rsel = rs;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $error("FAIL sb_empty got=0 exp=1");
            return;
        end
        e = sb.pop_front();
        n_run++;
        assert (m0_grant === e.m0g) else begin
            n_fail++;
            $error("FAIL %s m0_grant got=%b exp=%b", e.tag, m0_grant, e.m0g);
        end
        n_run++;
        assert (m1_grant === e.m1g) else begin
            n_fail++;
            $error("FAIL %s m1_grant got=%b exp=%b", e.tag, m1_grant, e.m1g);
        end
        n_run++;
        assert (s_sel === e.sel) else begin
            n_fail++;
            $error("FAIL %s s_sel got=%h exp=%h", e.tag, s_sel, e.sel);
        end
        n_run++;
        assert (s_wr === e.wr) else begin
            n_fail++;
            $error("FAIL %s s_wr got=%b exp=%b", e.tag, s_wr, e.wr);
        end
        n_run++;
        assert (s_addr === e.addr) else begin
            n_fail++;
            $error("FAIL %s s_addr got=%h exp=%h", e.tag, s_addr, e.addr);
        end
        n_run++;
        assert (s_din === e.din) else begin
            n_fail++;
            $error("FAIL %s s_din got=%h exp=%h", e.tag, s_din, e.din);
        end
        n_run++;
        assert (rsel === e.rsel) else begin
            n_fail++;
            $error("FAIL %s rsel got=%0d exp=%0d", e.tag, rsel, e.rsel);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        m0_req  = 1'b0; m1_req  = 1'b0;
        m0_wr   = 1'b0; m1_wr   = 1'b0;
        m0_addr = 16'h0; m1_addr = 16'h0;
        m0_dout = 32'h0; m1_dout = 32'h0;
        repeat (2) @(posedge clk);

        // reset release, idle bus
        @(negedge clk); reset_n = 1'b1;
        #1 push("rst", 1, 8'h00, 0, 16'h0000, 32'h0, 3'd0); check();

        // M0 read from slave 5
        @(negedge clk);
        m0_req = 1; m0_wr = 0; m0_addr = 16'hA000; m0_dout = 32'h11111111;
        #1 push("rd_comb", 1, 8'h20, 0, 16'hA000, 32'h11111111, 3'd0); check();
        @(posedge clk);
        #1 push("rd_reg", 1, 8'h20, 0, 16'hA000, 32'h11111111, 3'd5); check();

        // M0 write leaves rsel alone
        @(negedge clk);
        m0_wr = 1; m0_addr = 16'h6000; m0_dout = 32'h12345678;
        #1 push("wr_comb", 1, 8'h08, 1, 16'h6000, 32'h12345678, 3'd5); check();
        @(posedge clk);
        #1 push("wr_reg", 1, 8'h08, 1, 16'h6000, 32'h12345678, 3'd5); check();

        // back-to-back reads to slaves 0 and 7
        @(negedge clk);
        m0_wr = 0; m0_addr = 16'h0000; m0_dout = 32'h0;
        @(posedge clk);
        #1 push("b2b0", 1, 8'h01, 0, 16'h0000, 32'h0, 3'd0); check();
        @(negedge clk); m0_addr = 16'hE000;
        @(posedge clk);
        #1 push("b2b7", 1, 8'h80, 0, 16'hE000, 32'h0, 3'd7); check();

        // hand over to M1 write
        @(negedge clk);
        m0_req = 0;
        m1_req = 1; m1_wr = 1; m1_addr = 16'h2004; m1_dout = 32'hDEADBEEF;
        #1 push("hand_comb", 1, 8'h00, 0, 16'hE000, 32'h0, 3'd7); check();
        @(posedge clk);
        #1 push("m1_wr", 0, 8'h02, 1, 16'h2004, 32'hDEADBEEF, 3'd7); check();
        @(posedge clk);
        #1 push("m1_wr2", 0, 8'h02, 1, 16'h2004, 32'hDEADBEEF, 3'd7); check();

        // M1 read while M0 also requests: no preemption
        @(negedge clk);
        m0_req = 1;
        m1_wr = 0; m1_addr = 16'h8000; m1_dout = 32'h0;
        @(posedge clk);
        #1 push("m1_rd", 0, 8'h10, 0, 16'h8000, 32'h0, 3'd4); check();

        // M1 releases
        @(negedge clk);
        m1_req = 0; m0_addr = 16'hA000;
        #1 push("rel_comb", 0, 8'h00, 0, 16'h8000, 32'h0, 3'd4); check();
        @(posedge clk);
        #1 push("rel", 1, 8'h20, 0, 16'hA000, 32'h0, 3'd4); check();

        // sustained contention from M0_GNT
        @(negedge clk);
        m0_addr = 16'h4000;
        m1_req = 1; m1_wr = 0; m1_addr = 16'hC000; m1_dout = 32'hCAFEF00D;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
`ifdef BUS_FAIR_ARB_EN
            if (i >= 4)
                push("fair", 0, 8'h40, 0, 16'hC000, 32'hCAFEF00D,
                     (i >= 5) ? 3'd6 : 3'd2);
            else
                push("fair", 1, 8'h04, 0, 16'h4000, 32'h0, 3'd2);
`else
            push("contend", 1, 8'h04, 0, 16'h4000, 32'h0, 3'd2);
`endif
            check();
        end

        // let M1 own the bus and read slave 6
        @(negedge clk); m0_req = 0;
        repeat (2) @(posedge clk);
        #1 push("m1_own", 0, 8'h40, 0, 16'hC000, 32'hCAFEF00D, 3'd6); check();

        // asynchronous reset mid-read
        @(negedge clk); #2 reset_n = 1'b0;
        #1 push("rst_mid", 1, 8'h00, 0, 16'h4000, 32'h0, 3'd0); check();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk);
        #1 push("post_rst", 0, 8'h40, 0, 16'hC000, 32'hCAFEF00D, 3'd0); check();

        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $error("FAIL sb_left got=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
